mem_ctrl_cmd_sched: RTL and testbench

MEM_CTRL_CMD_SCHED -- requirements
Module: mem_ctrl_cmd_sched

---
 rtl/mem_ctrl_pkg.sv | 35 +++
 rtl/mem_ctrl_prio_rr_arb.sv | 41 ++++
 rtl/mem_ctrl_cmd_sched.sv | 201 ++++++++++++++++++++
 tb/tb_mem_ctrl_cmd_sched.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared types and widths for the memory-controller command scheduler.
// Optional requester aging is enabled by defining MEM_CTRL_SCHED_AGING_EN.
package mem_ctrl_pkg;

  localparam int CMD_ADDR_W = 16;
  localparam int CMD_LEN_W  = 4;
  localparam int CMD_ID_W   = 8;
  localparam int PRIO_W     = 3;
  localparam int IDX_W      = 3;
  localparam int AGE_W      = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_REFRESH
  } sched_state_t;

  typedef struct packed {
    logic [CMD_ADDR_W-1:0] addr;
    logic [CMD_LEN_W-1:0]  len;
    logic                  read;
    logic                  write;
    logic [CMD_ID_W-1:0]   id;
    logic [PRIO_W-1:0]     prio;
  } mem_cmd_t;

  function automatic logic [IDX_W-1:0] wrap_inc(
    input logic [IDX_W-1:0] idx,
    input int               n
  );
    if (int'(idx) + 1 >= n) return '0;
    return idx + 1'b1;
  endfunction

endpackage

// File: rtl/mem_ctrl_prio_rr_arb.sv
// Combinational picker: highest priority wins, ties resolved by
// distance from the round-robin pointer.
module mem_ctrl_prio_rr_arb
  import mem_ctrl_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]             valid,
  input  logic [NUM_REQ-1:0][PRIO_W-1:0] prio,
  input  logic [IDX_W-1:0]               rr_ptr,
  output logic [NUM_REQ-1:0]             grant,
  output logic [IDX_W-1:0]               grant_idx,
  output logic                           found
);

  logic [PRIO_W-1:0] best_p;
  int                best_d;
  int                d;

  always_comb begin
    grant_idx = '0;
    found     = 1'b0;
    best_p    = '0;
    best_d    = 0;
    d         = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      d = i - int'(rr_ptr);
      if (d < 0) d = d + NUM_REQ;
      if (valid[i] &&
          (!found || prio[i] > best_p ||
           (prio[i] == best_p && d < best_d))) begin
        found     = 1'b1;
        best_p    = prio[i];
        best_d    = d;
        grant_idx = IDX_W'(i);
      end
    end
    grant = found ? (NUM_REQ'(1) << grant_idx) : '0;
  end

endmodule

// File: rtl/mem_ctrl_cmd_sched.sv
// Command scheduler: arbitrates requesters onto one PHY command port
// and interleaves periodic refresh. Aging: MEM_CTRL_SCHED_AGING_EN.
module mem_ctrl_cmd_sched
  import mem_ctrl_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int AGE_LIMIT    = 64,
  parameter int REF_MAX_OWED = 8
) (
  input  logic                         clk_i,
  input  logic                         rst_n_i,
  input  logic [NUM_REQ-1:0]           req_valid_i,
  output logic [NUM_REQ-1:0]           req_ready_o,
  input  logic [NUM_REQ*CMD_ADDR_W-1:0] req_addr_i,
  input  logic [NUM_REQ*CMD_LEN_W-1:0] req_len_i,
  input  logic [NUM_REQ-1:0]           req_read_i,
  input  logic [NUM_REQ-1:0]           req_write_i,
  input  logic [NUM_REQ*CMD_ID_W-1:0]  req_id_i,
  input  logic [NUM_REQ*PRIO_W-1:0]    req_prio_i,
  output logic                         sched_cmd_valid_o,
  input  logic                         sched_cmd_ready_i,
  output logic [CMD_ADDR_W-1:0]        sched_cmd_addr_o,
  output logic [CMD_LEN_W-1:0]         sched_cmd_len_o,
  output logic                         sched_cmd_read_o,
  output logic                         sched_cmd_write_o,
  output logic [CMD_ID_W-1:0]          sched_cmd_id_o,
  output logic [PRIO_W-1:0]            sched_cmd_prio_o,
  output logic [IDX_W-1:0]             sched_grant_idx_o,
  input  logic [31:0]                  cfg_trefi_i,
  output logic                         ref_req_o,
  input  logic                         ref_ack_i,
  output logic                         err_cmd_o,
  output logic                         ref_overflow_o,
  output logic                         busy_o
);

  localparam int OWED_W = $clog2(REF_MAX_OWED + 1);

  sched_state_t                   state;
  logic [IDX_W-1:0]               rr_ptr;
  logic [IDX_W-1:0]               win_idx;
  logic [NUM_REQ-1:0]             win_oh;
  logic                           win_any;
  logic [NUM_REQ-1:0][PRIO_W-1:0] eff_prio;
  mem_cmd_t                       req_cmd;
  mem_cmd_t                       cmd_q;
  logic                           cmd_valid;
  logic [IDX_W-1:0]               grant_q;
  logic                           err_q;
  logic                           ref_req;
  logic [31:0]                    ref_cnt;
  logic [OWED_W-1:0]              ref_owed;
  logic                           ref_ovf;
  logic                           ref_tick;
  logic                           ref_done;
  logic                           ref_pend;
  logic                           accept;

`ifdef MEM_CTRL_SCHED_AGING_EN
  logic [NUM_REQ-1:0][AGE_W-1:0] age;

  // a requester that drops valid restarts its wait from zero
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      age <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!req_valid_i[i] || req_ready_o[i])
          age[i] <= '0;
        else if (age[i] < AGE_W'(AGE_LIMIT))
          age[i] <= age[i] + 1'b1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++)
      eff_prio[i] = (age[i] >= AGE_W'(AGE_LIMIT)) ? '1
                  : req_prio_i[i*PRIO_W +: PRIO_W];
  end
`else
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++)
      eff_prio[i] = req_prio_i[i*PRIO_W +: PRIO_W];
  end
`endif

  mem_ctrl_prio_rr_arb #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .valid     (req_valid_i),
    .prio      (eff_prio),
    .rr_ptr    (rr_ptr),
    .grant     (win_oh),
    .grant_idx (win_idx),
    .found     (win_any)
  );

  always_comb begin
    req_cmd = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (IDX_W'(i) == win_idx) begin
        req_cmd.addr  = req_addr_i[i*CMD_ADDR_W +: CMD_ADDR_W];
        req_cmd.len   = req_len_i[i*CMD_LEN_W +: CMD_LEN_W];
        req_cmd.read  = req_read_i[i];
        req_cmd.write = req_write_i[i];
        req_cmd.id    = req_id_i[i*CMD_ID_W +: CMD_ID_W];
        req_cmd.prio  = req_prio_i[i*PRIO_W +: PRIO_W];
      end
    end
  end

  // refresh owed while enabled outranks every requester
  assign ref_pend = (ref_owed != '0) && (cfg_trefi_i != '0);
  assign ref_tick = (cfg_trefi_i != '0) &&
                    (ref_cnt >= cfg_trefi_i - 32'd1);
  assign ref_done = (state == ST_REFRESH) && ref_ack_i;
  assign accept   = rst_n_i && (state == ST_IDLE) &&
                    !ref_pend && win_any;

  assign req_ready_o = accept ? win_oh : '0;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ref_cnt  <= '0;
      ref_owed <= '0;
      ref_ovf  <= 1'b0;
    end else begin
      ref_cnt <= (cfg_trefi_i == '0 || ref_tick) ? '0
               : ref_cnt + 32'd1;
      if (ref_tick && !ref_done) begin
        if (ref_owed == OWED_W'(REF_MAX_OWED))
          ref_ovf <= 1'b1;
        else
          ref_owed <= ref_owed + 1'b1;
      end else if (ref_done && !ref_tick) begin
        ref_owed <= ref_owed - 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state     <= ST_IDLE;
      rr_ptr    <= '0;
      cmd_q     <= '0;
      cmd_valid <= 1'b0;
      grant_q   <= '0;
      err_q     <= 1'b0;
      ref_req   <= 1'b0;
    end else begin
      err_q <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (ref_pend) begin
            state   <= ST_REFRESH;
            ref_req <= 1'b1;
          end else if (accept) begin
            if (req_cmd.read ^ req_cmd.write) begin
              cmd_q     <= req_cmd;
              cmd_valid <= 1'b1;
              grant_q   <= win_idx;
              state     <= ST_ISSUE;
            end else begin
              err_q  <= 1'b1;
              rr_ptr <= wrap_inc(win_idx, NUM_REQ);
            end
          end
        end
        ST_ISSUE: begin
          if (sched_cmd_ready_i) begin
            cmd_valid <= 1'b0;
            rr_ptr    <= wrap_inc(grant_q, NUM_REQ);
            state     <= ST_IDLE;
          end
        end
        ST_REFRESH: begin
          if (ref_ack_i) begin
            ref_req <= 1'b0;
            state   <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign sched_cmd_valid_o = cmd_valid;
  assign sched_cmd_addr_o  = cmd_q.addr;
  assign sched_cmd_len_o   = cmd_q.len;
  assign sched_cmd_read_o  = cmd_q.read;
  assign sched_cmd_write_o = cmd_q.write;
  assign sched_cmd_id_o    = cmd_q.id;
  assign sched_cmd_prio_o  = cmd_q.prio;
  assign sched_grant_idx_o = grant_q;
  assign ref_req_o         = ref_req;
  assign err_cmd_o         = err_q;
  assign ref_overflow_o    = ref_ovf;
  assign busy_o            = (state != ST_IDLE);

endmodule

// File: tb/tb_mem_ctrl_cmd_sched.sv
// Bench for mem_ctrl_cmd_sched: vector table, directed corner cases and
// random traffic against a cycle-level reference model.
module tb_mem_ctrl_cmd_sched;
  import mem_ctrl_pkg::*;

  localparam int N       = 4;
  localparam int AGE_LIM = 16;
  localparam int MAXO    = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]       vld, rd, wr, rdy;
  logic [N-1:0][15:0] addr;
  logic [N-1:0][3:0]  len;
  logic [N-1:0][7:0]  id;
  logic [N-1:0][2:0]  prio;
  logic               cv, cr, crd, cwr;
  logic [15:0]        ca;
  logic [3:0]         cl;
  logic [7:0]         cid;
  logic [2:0]         cp, gidx;
  logic [31:0]        trefi;
  logic               rreq, rack, err, ovf, busy;

  mem_ctrl_cmd_sched #(
    .NUM_REQ(N), .AGE_LIMIT(AGE_LIM), .REF_MAX_OWED(MAXO)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .req_valid_i(vld), .req_ready_o(rdy),
    .req_addr_i(addr), .req_len_i(len),
    .req_read_i(rd), .req_write_i(wr),
    .req_id_i(id), .req_prio_i(prio),
    .sched_cmd_valid_o(cv), .sched_cmd_ready_i(cr),
    .sched_cmd_addr_o(ca), .sched_cmd_len_o(cl),
    .sched_cmd_read_o(crd), .sched_cmd_write_o(cwr),
    .sched_cmd_id_o(cid), .sched_cmd_prio_o(cp),
    .sched_grant_idx_o(gidx), .cfg_trefi_i(trefi),
    .ref_req_o(rreq), .ref_ack_i(rack),
    .err_cmd_o(err), .ref_overflow_o(ovf), .busy_o(busy)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // reference model
  int          m_rr, m_owed, m_idx;
  int unsigned m_cnt;
  bit          m_issue, m_refr, m_ovf, m_err;
  logic [32:0] m_fld;
  int          m_age[N];

  task automatic model_reset();
    m_rr = 0; m_owed = 0; m_idx = 0; m_cnt = 0;
    m_issue = 0; m_refr = 0; m_ovf = 0; m_err = 0; m_fld = '0;
    for (int i = 0; i < N; i++) m_age[i] = 0;
  endtask

  function automatic int eff(int i);
`ifdef MEM_CTRL_SCHED_AGING_EN
    if (m_age[i] >= AGE_LIM) return 7;
`endif
    return int'(prio[i]);
  endfunction

  function automatic int m_winner();
    for (int p = 7; p >= 0; p--)
      for (int k = 0; k < N; k++) begin
        int i = (m_rr + k) % N;
        if (vld[i] && eff(i) == p) return i;
      end
    return -1;
  endfunction

  task automatic model_cycle();
    int w;
    logic [N-1:0] er;
    bit tick, done, gate;
    gate = (m_owed > 0) && (trefi != 0);
    w = m_winner();
    er = '0;
    if (!m_issue && !m_refr && !gate && w >= 0) er[w] = 1'b1;
    chk("ready", rdy, er);
    chk("cmd_valid", cv, m_issue);
    chk("cmd_fields", {ca, cl, crd, cwr, cid, cp}, m_fld);
    chk("grant_idx", gidx, m_idx);
    chk("ref_req", rreq, m_refr);
    chk("err_cmd", err, m_err);
    chk("ref_overflow", ovf, m_ovf);
    chk("busy", busy, m_issue | m_refr);
    tick = (trefi != 0) && (m_cnt == trefi - 1);
    done = m_refr && rack;
    m_cnt = (trefi == 0 || tick) ? 0 : m_cnt + 1;
    if (tick && !done) begin
      if (m_owed == MAXO) m_ovf = 1; else m_owed++;
    end else if (done && !tick) m_owed--;
    for (int i = 0; i < N; i++)
      if (!vld[i] || er[i]) m_age[i] = 0;
      else if (m_age[i] < AGE_LIM) m_age[i]++;
    m_err = 0;
    if (m_refr) begin
      if (rack) m_refr = 0;
    end else if (m_issue) begin
      if (cr) begin m_issue = 0; m_rr = (m_idx + 1) % N; end
    end else if (gate) begin
      m_refr = 1;
    end else if (w >= 0) begin
      if (rd[w] ^ wr[w]) begin
        m_issue = 1; m_idx = w;
        m_fld = {addr[w], len[w], rd[w], wr[w], id[w], prio[w]};
      end else begin
        m_err = 1; m_rr = (w + 1) % N;
      end
    end
  endtask

  task automatic fin();
    model_cycle();
    @(posedge clk); #1;
  endtask

  task automatic cyc();
    @(negedge clk);
    fin();
  endtask

  task automatic do_reset();
    rst_n = 1'b0; vld = '1; cr = 0; rack = 0; trefi = 0;
    #1;
    chk("rst_cmd_valid", cv, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ref_req", rreq, 0);
    chk("rst_ready", rdy, 0);
    @(negedge clk);
    chk("rst_fields", {ca, cl, crd, cwr, cid, cp}, 0);
    chk("rst_idx", gidx, 0);
    chk("rst_err", err, 0);
    chk("rst_ovf", ovf, 0);
    @(posedge clk); #1;
    vld = '0; rst_n = 1'b1;
    model_reset();
  endtask

  typedef struct {
    logic [N-1:0]      v;
    logic [N-1:0][2:0] p;
    logic [N-1:0]      r;
    logic [N-1:0]      w;
    logic [N-1:0]      er;
    bit                ecv;
    int                ei;
    bit                eerr;
  } vec_t;

  vec_t tv[9];
  int   q[$];
  int   n_ack;
  bit   got;
  logic [N-1:0] acc;
  int   t;
  int   exp_rr[5];

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < N; i++) begin
      addr[i] = 16'h1000 + 16'(i * 16'h111);
      len[i]  = 4'(i + 1);
      id[i]   = 8'hA0 + 8'(i);
      prio[i] = '0;
    end
    rd = '0; wr = '0; vld = '0; cr = 0; rack = 0; trefi = 0;

    tv[0] = '{4'b0011, {3'd0,3'd0,3'd5,3'd2}, 4'b1111, 4'b0000, 4'b0010, 1, 1, 0};
    tv[1] = '{4'b1111, {3'd3,3'd3,3'd3,3'd3}, 4'b1111, 4'b0000, 4'b0001, 1, 0, 0};
    tv[2] = '{4'b1100, {3'd4,3'd4,3'd0,3'd0}, 4'b1111, 4'b0000, 4'b0100, 1, 2, 0};
    tv[3] = '{4'b1010, {3'd7,3'd0,3'd7,3'd0}, 4'b1111, 4'b0000, 4'b0010, 1, 1, 0};
    tv[4] = '{4'b0000, {3'd1,3'd2,3'd3,3'd4}, 4'b1111, 4'b0000, 4'b0000, 0, 0, 0};
    tv[5] = '{4'b0100, {3'd0,3'd0,3'd0,3'd0}, 4'b0100, 4'b0100, 4'b0100, 0, 0, 1};
    tv[6] = '{4'b1000, {3'd0,3'd0,3'd0,3'd0}, 4'b0000, 4'b0000, 4'b1000, 0, 0, 1};
    tv[7] = '{4'b1001, {3'd1,3'd0,3'd0,3'd0}, 4'b1111, 4'b0000, 4'b1000, 1, 3, 0};
    tv[8] = '{4'b0110, {3'd0,3'd6,3'd6,3'd0}, 4'b0000, 4'b0110, 4'b0010, 1, 1, 0};

    do_reset();

    for (int k = 0; k < 9; k++) begin
      do_reset();
      vld = tv[k].v; prio = tv[k].p; rd = tv[k].r; wr = tv[k].w; cr = 1;
      @(negedge clk);
      chk($sformatf("tab%0d_ready", k), rdy, tv[k].er);
      fin();
      @(negedge clk);
      chk($sformatf("tab%0d_cmd_valid", k), cv, tv[k].ecv);
      chk($sformatf("tab%0d_grant_idx", k), gidx, tv[k].ei);
      chk($sformatf("tab%0d_err", k), err, tv[k].eerr);
      if (tv[k].ecv) chk($sformatf("tab%0d_id", k), cid, 8'hA0 + tv[k].ei);
      fin();
    end

    // round-robin order among equal priorities
    do_reset();
    vld = '1; rd = '1; wr = '0; cr = 1;
    for (int i = 0; i < N; i++) prio[i] = 3'd3;
    q.delete();
    for (int c = 0; c < 20 && q.size() < 5; c++) begin
      @(negedge clk);
      if (cv) q.push_back(int'(gidx));
      fin();
    end
    chk("rr_grant_count", q.size(), 5);
    exp_rr = '{0, 1, 2, 3, 0};
    for (int i = 0; i < q.size() && i < 5; i++)
      chk($sformatf("rr_grant%0d", i), q[i], exp_rr[i]);

    // reset while a command is waiting on the PHY: dropped, not replayed
    do_reset();
    vld = 4'b0010; rd = '1; wr = '0; prio = '0; cr = 0;
    cyc(); cyc();
    chk("issue_held", cv, 1);
    do_reset();
    cr = 1;
    cyc(); cyc();
    chk("no_replay", cv, 0);

    // refresh owed saturation and sticky overflow
    do_reset();
    trefi = 100;
    for (int c = 0; c < 850; c++) cyc();
    chk("ovf_before", ovf, 0);
    chk("refresh_pending", rreq, 1);
    for (int c = 0; c < 100; c++) cyc();
    chk("ovf_after", ovf, 1);
    n_ack = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (rreq) begin rack = 1; n_ack++; end
      else rack = 0;
      fin();
    end
    rack = 0;
    chk("owed_drained", n_ack, MAXO);
    chk("ovf_sticky", ovf, 1);

    // request arriving during refresh waits for the ack
    do_reset();
    trefi = 20;
    got = 0;
    for (int c = 0; c < 40 && !got; c++) begin
      @(negedge clk);
      if (rreq) got = 1;
      fin();
    end
    chk("ref_entry", got, 1);
    vld = 4'b0001; rd = '1; wr = '0; prio = '0; prio[0] = 3'd1; cr = 1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("ref_blocks_ready", rdy, 0);
      fin();
    end
    rack = 1;
    @(negedge clk);
    chk("ref_ack_ready", rdy, 0);
    fin();
    rack = 0;
    @(negedge clk);
    chk("post_ref_ready", rdy, 4'b0001);
    chk("post_ref_req", rreq, 0);
    fin();
    @(negedge clk);
    chk("post_ref_cmd", cv, 1);
    fin();

`ifdef MEM_CTRL_SCHED_AGING_EN
    do_reset();
    vld = '1; rd = '1; wr = '0; cr = 1;
    prio[0] = 3'd0; prio[1] = 3'd6; prio[2] = 3'd6; prio[3] = 3'd6;
    got = 0;
    for (int c = 0; c < 18 && !got; c++) begin
      @(negedge clk);
      if (rdy[0]) got = 1;
      fin();
    end
    chk("aging_grant", got, 1);
`endif

    // random traffic against the model
    do_reset();
    trefi = 37;
    acc = '0;
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < N; i++)
        if (!vld[i] || acc[i]) begin
          vld[i]  = ($urandom_range(0, 3) != 0);
          prio[i] = 3'($urandom);
          addr[i] = 16'($urandom);
          len[i]  = 4'($urandom);
          id[i]   = 8'($urandom);
          t = $urandom_range(0, 9);
          rd[i] = (t < 4) || (t == 9);
          wr[i] = (t >= 4 && t < 8) || (t == 9);
        end
      cr = 1'($urandom);
      @(negedge clk);
      acc  = rdy & vld;
      rack = rreq & 1'($urandom);
      fin();
    end
    rack = 0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
